// File: rtl/nibble_serializer.sv
// Parallel-to-serial shifter: first bit one cycle after accept, then one bit per transfer.
// Backpressure: out_ready low freezes all state; in_ready rises only with the last bit's transfer.
module nibble_serializer #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_data,
    output logic             out_last,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shift_nxt;
    logic [CW-1:0]    cnt;
    logic             accept;
    logic             xfer;

    assign out_valid = (state == SHIFT);
    assign busy      = (state == SHIFT);
    assign out_last  = (state == SHIFT) && (cnt == '0);
    assign out_data  = MSB_FIRST ? shift_reg[WIDTH-1] : shift_reg[0];

    // Zero-bubble handoff: the next word is taken on the same edge the last bit leaves.
    assign in_ready  = !rst && ((state == IDLE) || (out_last && out_ready));
    assign accept    = in_valid && in_ready;
    assign xfer      = out_valid && out_ready;

    always_comb begin
        shift_nxt = '0;
        if (MSB_FIRST)
            shift_nxt = {shift_reg[WIDTH-2:0], 1'b0};
        else
            shift_nxt = {1'b0, shift_reg[WIDTH-1:1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shift_reg <= '0;
            cnt       <= '0;
        end else if (accept) begin
            shift_reg <= in_data;
            cnt       <= CW'(WIDTH - 1);
            state     <= SHIFT;
        end else if (xfer) begin
            shift_reg <= shift_nxt;
            if (cnt == '0)
                state <= IDLE;
            else
                cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: tb/tb_nibble_serializer.sv
// Bench for nibble_serializer: three parameterisations, directed scenarios plus random traffic,
// expected bit stream queued at accept time and popped by a monitor thread on each transfer.
module tb_nibble_serializer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       iv  [3];
    logic       ir  [3];
    logic       ov  [3];
    logic       ord [3];
    logic       od  [3];
    logic       ol  [3];
    logic       bz  [3];
    logic [7:0] id  [3];

    int         wid  [3];
    bit         msbf [3];
    int         act;
    logic [1:0] expq [$];
    int         errors = 0;
    int         checks = 0;
    int         n_acc  = 0;
    int         n_last = 0;

    always #5 clk = ~clk;

    nibble_serializer #(.WIDTH(4), .MSB_FIRST(1)) u0 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0][3:0]),
        .out_valid(ov[0]), .out_ready(ord[0]), .out_data(od[0]), .out_last(ol[0]), .busy(bz[0]));

    nibble_serializer #(.WIDTH(4), .MSB_FIRST(0)) u1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1][3:0]),
        .out_valid(ov[1]), .out_ready(ord[1]), .out_data(od[1]), .out_last(ol[1]), .busy(bz[1]));

    nibble_serializer #(.WIDTH(8), .MSB_FIRST(1)) u2 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(id[2]),
        .out_valid(ov[2]), .out_ready(ord[2]), .out_data(od[2]), .out_last(ol[2]), .busy(bz[2]));

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // A word becomes its WIDTH bits in wire order, the final one flagged as last.
    task automatic monitor();
        logic [1:0] e;
        int         a;
        int         idx;
        forever begin
            @(negedge clk);
            a = act;
            if (rst) chk("ready_in_reset", 32'(ir[a]), 32'd0);
            chk("busy_vs_valid", 32'(bz[a]), 32'(ov[a]));
            if (ov[a] && ord[a]) begin
                if (expq.size() == 0) begin
                    chk("unexpected_bit", 32'(expq.size()), 32'd1);
                end else begin
                    e = expq.pop_front();
                    chk("out_data", 32'(od[a]), 32'(e[0]));
                    chk("out_last", 32'(ol[a]), 32'(e[1]));
                    if (ol[a]) n_last++;
                end
            end
            if (iv[a] && ir[a]) begin
                n_acc++;
                for (int k = 0; k < wid[a]; k++) begin
                    idx = msbf[a] ? (wid[a] - 1 - k) : k;
                    expq.push_back({(k == wid[a] - 1), id[a][idx]});
                end
            end
        end
    endtask

    task automatic put(input int a, input logic [7:0] w);
        act   = a;
        iv[a] = 1'b1;
        id[a] = w;
        step();
        iv[a] = 1'b0;
    endtask

    task automatic rnd(input int a, input int nwords);
        int sent;
        int cyc;
        bit acc;
        sent = 0;
        cyc  = 0;
        act  = a;
        iv[a] = 1'b0;
        while (sent < nwords && cyc < 40000) begin
            ord[a] = ($urandom % 4) != 0;
            if (!iv[a] && ($urandom % 2) == 1) begin
                iv[a] = 1'b1;
                id[a] = 8'($urandom);
            end
            @(negedge clk);
            acc = iv[a] && ir[a];
            @(posedge clk);
            #1;
            if (acc) begin
                sent++;
                iv[a] = 1'b0;
            end
            cyc++;
        end
        chk("rnd_words_sent", 32'(sent), 32'(nwords));
        iv[a]  = 1'b0;
        ord[a] = 1'b1;
        for (int i = 0; i < 40 && ov[a]; i++) step();
        chk("rnd_drained_valid", 32'(ov[a]), 32'd0);
        chk("rnd_queue_empty", 32'(expq.size()), 32'd0);
    endtask

    initial begin
        wid  = '{4, 4, 8};
        msbf = '{1'b1, 1'b0, 1'b1};
        act  = 0;
        for (int i = 0; i < 3; i++) begin
            iv[i]  = 1'b0;
            ord[i] = 1'b1;
            id[i]  = 8'h00;
        end
        fork
            monitor();
        join_none

        // Reset values, asserted between clock edges.
        #1 rst = 1'b1;
        #2;
        chk("rst_out_valid", 32'(ov[0]), 32'd0);
        chk("rst_out_data",  32'(od[0]), 32'd0);
        chk("rst_out_last",  32'(ol[0]), 32'd0);
        chk("rst_busy",      32'(bz[0]), 32'd0);
        chk("rst_in_ready",  32'(ir[0]), 32'd0);
        step();
        step();
        rst = 1'b0;
        #1;
        chk("idle_in_ready", 32'(ir[0]), 32'd1);

        // 1011 MSB first: four bits then idle.
        put(0, 8'b1011);
        chk("latency_valid", 32'(ov[0]), 32'd1);
        repeat (4) step();
        chk("single_done_valid", 32'(ov[0]), 32'd0);
        chk("single_queue_empty", 32'(expq.size()), 32'd0);

        // 1011 LSB first.
        put(1, 8'b1011);
        repeat (4) step();
        chk("lsb_done_valid", 32'(ov[1]), 32'd0);
        chk("lsb_queue_empty", 32'(expq.size()), 32'd0);

        // A then 5 back to back with in_valid held.
        act   = 0;
        iv[0] = 1'b1;
        id[0] = 8'hA;
        step();
        id[0] = 8'h5;
        for (int c = 1; c <= 8; c++) begin
            chk("b2b_valid", 32'(ov[0]), 32'd1);
            if (c == 4) chk("b2b_ready_on_last", 32'(ir[0] & ol[0]), 32'd1);
            if (c == 5) iv[0] = 1'b0;
            step();
        end
        chk("b2b_done_valid", 32'(ov[0]), 32'd0);
        chk("b2b_queue_empty", 32'(expq.size()), 32'd0);

        // 1100 with a three-cycle stall after the second bit.
        put(0, 8'b1100);
        step();
        step();
        ord[0] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("stall_valid", 32'(ov[0]), 32'd1);
            chk("stall_data",  32'(od[0]), 32'd0);
            chk("stall_last",  32'(ol[0]), 32'd0);
            step();
        end
        ord[0] = 1'b1;
        repeat (3) step();
        chk("stall_done_valid", 32'(ov[0]), 32'd0);
        chk("stall_queue_empty", 32'(expq.size()), 32'd0);

        // F interrupted by an unaligned reset after two bits, then 3.
        put(0, 8'hF);
        step();
        step();
        #2 rst = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(ov[0]), 32'd0);
        chk("midrst_out_data",  32'(od[0]), 32'd0);
        chk("midrst_busy",      32'(bz[0]), 32'd0);
        chk("midrst_in_ready",  32'(ir[0]), 32'd0);
        expq.delete();
        n_acc  = 0;
        n_last = 0;
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("postrst_in_ready", 32'(ir[0]), 32'd1);
        put(0, 8'h3);
        repeat (6) step();
        chk("postrst_done_valid", 32'(ov[0]), 32'd0);
        chk("postrst_queue_empty", 32'(expq.size()), 32'd0);

        // Random valid/ready traffic.
        rnd(0, 1000);
        rnd(1, 200);
        rnd(2, 1000);
        chk("one_last_per_word", 32'(n_last), 32'(n_acc));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nibble_serializer.md
NIBBLE_SERIALIZER -- requirements
Module: nibble_serializer

Interface
REQ-001 Parameter WIDTH, default 4, number of bits per parallel word (legal 2..32).
REQ-002 Parameter MSB_FIRST, default 1; 1 = bit WIDTH-1 sent first, 0 = bit 0 sent first.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  parallel word offered.
REQ-006 in_ready  output  1  serializer accepts word this cycle.
REQ-007 in_data  input  WIDTH  parallel word, sampled on accept.
REQ-008 out_valid  output  1  serial bit presented.
REQ-009 out_ready  input  1  downstream consumes bit this cycle.
REQ-010 out_data  output  1  current serial bit.
REQ-011 out_last  output  1  high with the final bit of a word.
REQ-012 busy  output  1  word in progress (state SHIFT).

Function
REQ-013 Accept = in_valid & in_ready at a rising edge; bit transfer = out_valid & out_ready at a rising edge.
REQ-014 FSM states IDLE and SHIFT only; IDLE -> SHIFT on accept; SHIFT -> IDLE on transfer of last bit with no simultaneous accept; SHIFT -> SHIFT on last-bit transfer with simultaneous accept.
REQ-015 in_ready = 1 in IDLE; in SHIFT, in_ready = out_last & out_ready (combinational, zero-bubble back-to-back); 0 otherwise.
REQ-016 On accept, in_data is captured into a WIDTH-bit shift register and a bit counter loads WIDTH-1.
REQ-017 Latency: first bit of an accepted word appears on out_data with out_valid = 1 in the cycle after the accept edge.
REQ-018 out_valid = 1 exactly when state = SHIFT; out_data, out_last driven from registers only (no combinational path from in_data).
REQ-019 MSB_FIRST = 1: out_data = shift_reg[WIDTH-1], shift left by one per transfer; MSB_FIRST = 0: out_data = shift_reg[0], shift right by one per transfer; vacated bits fill with 0.
REQ-020 Bit counter decrements by one per transfer; out_last = 1 when counter = 0 in SHIFT; counter never wraps below 0.
REQ-021 out_ready = 0 in SHIFT: out_data, out_last, counter, shift register hold unchanged (stall of any length).
REQ-022 in_valid while in_ready = 0 is ignored; in_data is not sampled; no word is lost provided upstream holds in_valid.
REQ-023 busy = (state = SHIFT).
REQ-024 Exactly WIDTH transfers occur per accepted word; out_last asserts on exactly one of them.

Reset
REQ-025 rst = 1 forces immediately, independent of clk: state IDLE, shift register 0, counter 0, out_valid 0, out_data 0, out_last 0, busy 0, in_ready 1 once rst deasserts.
REQ-026 in_ready = 0 while rst = 1.
REQ-027 rst asserted mid-word abandons the word; no remaining bits are emitted after rst deasserts; first edge after deassert with in_valid = 1 accepts a new word.

Verification
REQ-028 WIDTH=4, MSB_FIRST=1, out_ready=1, in_data=4'b1011 accepted at edge 0 -> out_data 1,0,1,1 on cycles 1-4, out_last only on cycle 4, out_valid 0 on cycle 5.
REQ-029 MSB_FIRST=0, in_data=4'b1011 -> out_data 1,1,0,1; out_last on 4th bit.
REQ-030 Words 4'hA then 4'h5 with in_valid held, out_ready=1 -> 8 consecutive bits 1,0,1,0,0,1,0,1, out_valid never drops, second accept coincides with first out_last transfer.
REQ-031 out_ready low for 3 cycles after 2nd bit of 4'b1100 -> out_data stays 0 and counter holds during stall; bits complete as 1,1,0,0 after release.
REQ-032 rst pulsed (not clock-aligned) after 2nd bit of 4'hF -> out_valid, out_data, busy 0 immediately; after deassert next word 4'h3 emits 0,0,1,1 with no residual 1s.
REQ-033 Random in_valid/out_ready, 1000 words, WIDTH 4 and 8 -> scoreboard reassembled words match accepted words in order, one out_last per word.
